// File: rtl/int_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package int_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter width for a WIDTH-iteration loop: $clog2(WIDTH+1).
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/int_mul_seq.sv
// Iterative radix-2 shift-add multiplier with valid/ready handshakes and
// per-transaction signed/unsigned mode; fixed latency of WIDTH+1 cycles.
module int_mul_seq
  import int_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0]      LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_nxt;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0]   result_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [CW-1:0]        cnt_r;
  logic                 neg_r;
  logic                 last_s;

  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic sgn);
    logic [WIDTH-1:0] m;
    if (sgn && x[WIDTH-1]) begin
      m = ~x + ONE_W;
    end else begin
      m = x;
    end
    return m;
  endfunction

  assign last_s    = (cnt_r == LAST);
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign result    = result_r;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt = MUL;
        else          state_nxt = IDLE;
      end
      MUL: begin
        if (last_s) state_nxt = FIX;
        else        state_nxt = MUL;
      end
      FIX:  state_nxt = DONE;
      DONE: begin
        if (out_ready) state_nxt = IDLE;
        else           state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, shift-add iterations and final sign fix-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
      neg_r    <= 1'b0;
      result_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mcand_r  <= {{WIDTH{1'b0}}, magnitude(num1, is_signed)};
            mplier_r <= magnitude(num2, is_signed);
            neg_r    <= is_signed & (num1[WIDTH-1] ^ num2[WIDTH-1]);
            acc_r    <= '0;
            cnt_r    <= '0;
          end
        end
        MUL: begin
          if (mplier_r[0]) acc_r <= acc_r + mcand_r;
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + CNT_ONE;
        end
        FIX: begin
          if (neg_r) result_r <= ~acc_r + ONE_2W;
          else       result_r <= acc_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/int_mul_seq.md
# int_mul_seq

Parametrised, handshaked successor to the fixed 8-bit registered multiplier in the encrypted-IP multiply/display design. It accepts one operand pair per transaction over a valid/ready interface and computes the full-width product with an iterative radix-2 shift-add datapath, so area stays small at large widths. Signed or unsigned mode is selected per transaction. It sits between the switch/operand capture logic and the display driver, which consumes `result`.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `in_valid`  in  1  operand pair and mode are valid.
- `in_ready`  out  1  block can accept a transaction.
- `num1`  in  WIDTH  multiplicand.
- `num2`  in  WIDTH  multiplier.
- `is_signed`  in  1  1 = two's-complement operands and result; 0 = unsigned.
- `out_valid`  out  1  `result` holds a completed product.
- `out_ready`  in  1  consumer accepts `result`.
- `result`  out  2*WIDTH  product.

## Operation
- States: IDLE, MUL, FIX, DONE. Reset forces IDLE. `in_ready`=1 only in IDLE; `out_valid`=1 only in DONE.
- IDLE: on `in_valid & in_ready`, capture `num1`, `num2`, `is_signed`.
  - In signed mode, store the magnitudes (|x|, WIDTH-bit unsigned) and `neg = sign1 ^ sign2`.
  - |−2^(WIDTH−1)| = 2^(WIDTH−1) fits in WIDTH unsigned bits and needs no special case.
  - Clear the 2*WIDTH accumulator and the counter, then go to MUL.
- MUL: once per cycle, if multiplier LSB=1 then accumulator += multiplicand shifted by the current bit index. Shift the multiplier right and increment the counter. After exactly WIDTH iterations, go to FIX.
- FIX: if `neg`, result ← two's-complement negate of the accumulator (mod 2^(2*WIDTH)); else result ← accumulator. Go to DONE.
- DONE: hold `result` stable. On `out_ready`, return to IDLE.
- Unsigned result is exact in 2*WIDTH bits.
- Signed result is exact in 2*WIDTH bits, including (−2^(WIDTH−1))² = 2^(2*WIDTH−2).
- A zero operand still runs all WIDTH iterations. No early termination, so latency is fixed.
- `in_valid` outside IDLE is ignored. Operands are not re-sampled mid-operation.
- `out_ready` outside DONE is ignored.
- The `result` register holds its last value after leaving DONE. It updates only in FIX.

## Timing
- Reset values: `in_ready`=1 once reset deasserts (state IDLE), `out_valid`=0, `result`=0. Accumulator, counter, operand registers and `neg` are all 0.
- Reset is asynchronous and can occur in any state, including mid-MUL or DONE with `out_valid`=1. It aborts the transaction with no output; the next product starts only on a new handshake.
- Latency: if the accepting edge is edge 0, `out_valid` rises after edge WIDTH+1, i.e. WIDTH cycles in MUL plus 1 cycle in FIX. WIDTH=8 gives out_valid after edge 9.
- `in_ready` falls the cycle after acceptance. It rises the cycle after the DONE/`out_ready` handshake.
- Minimum transaction period is WIDTH+3 cycles with `out_ready` held high.
- Backpressure: DONE may last indefinitely. `result` and `out_valid` stay stable until `out_ready`.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Structure
- Shared package `int_mul_pkg` holds:
  - the state enum (IDLE, MUL, FIX, DONE, 2-bit encoding);
  - the counter-width constant, $clog2(WIDTH+1).
- Single module. Control FSM and datapath are tightly coupled, so no sub-module is warranted.
- Accumulator, counter, operand registers and `neg` use the same asynchronous active-low reset as the FSM.

## Test plan
- WIDTH=8, unsigned 200×150 → `out_valid` after 9 edges, `result`=0x7530. Also 255×255 → 0xFE01.
- WIDTH=8, signed: −3×5 → 0xFFF1; −128×−128 → 0x4000; −128×127 → 0xC080; 0×−1 → 0x0000.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid`. Required: `result` stable, `out_valid` high, `in_ready` low, and `in_valid` pulses ignored. Raise `out_ready` → IDLE next cycle.
- Reset mid-MUL, at cycle 4 of 8. Required: outputs return immediately to reset values and no `out_valid` appears. A new transaction 7×9 → 0x003F.
- Back-to-back with `in_valid` and `out_ready` held high: accept every WIDTH+3 cycles. Check throughput and a per-transaction scoreboard against a reference model for 1,000 random operand pairs, mixed modes.
- WIDTH=16 and WIDTH=3 builds: random signed/unsigned against the model. Check latency equals WIDTH+1 and corner operands (min/max values).
